// File: rtl/rob_commit_ctrl_pkg.sv
// Shared widths, exception code and FSM encoding for ROB retirement.
package rob_commit_ctrl_pkg;

  localparam int ADDR_BUS     = 32;
  localparam int DATA_BUS     = 32;
  localparam int RF_ADDR_BUS  = 5;
  localparam int EXC_TYPE_BUS = 5;

  localparam logic [EXC_TYPE_BUS-1:0] EXC_NONE = '0;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } commit_state_e;

  function automatic logic [ADDR_BUS-1:0] calc_epc(
    input logic [ADDR_BUS-1:0] pc,
    input logic                ds
  );
    return ds ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// ROB head commit port: head fields from the ROB, pop strobe back.
interface rob_commit_ctrl_if
  import rob_commit_ctrl_pkg::*;
();

  logic                    can_commit;
  logic                    commit_en;
  logic                    reg_write_add;
  logic                    reg_write_en;
  logic [RF_ADDR_BUS-1:0]  reg_write_addr;
  logic [DATA_BUS-1:0]     reg_write_data;
  logic                    reg_write_lo_en;
  logic [DATA_BUS-1:0]     reg_write_lo_data;
  logic [EXC_TYPE_BUS-1:0] exception_type;
  logic                    is_delayslot;
  logic [ADDR_BUS-1:0]     pc;

  modport master (
    output can_commit,
    output reg_write_add,
    output reg_write_en,
    output reg_write_addr,
    output reg_write_data,
    output reg_write_lo_en,
    output reg_write_lo_data,
    output exception_type,
    output is_delayslot,
    output pc,
    input  commit_en
  );

  modport slave (
    input  can_commit,
    input  reg_write_add,
    input  reg_write_en,
    input  reg_write_addr,
    input  reg_write_data,
    input  reg_write_lo_en,
    input  reg_write_lo_data,
    input  exception_type,
    input  is_delayslot,
    input  pc,
    output commit_en
  );

endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retirement: pops the ROB head, writes the regfile,
// raises precise exceptions and holds flush until acknowledged.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int EXC_TYPE_WIDTH = EXC_TYPE_BUS,
  parameter logic [EXC_TYPE_WIDTH-1:0] EXC_NONE =
    rob_commit_ctrl_pkg::EXC_NONE,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  rob_commit_ctrl_if.slave          rob,
  input  logic                      halt,
  output logic                      rf_write_add,
  output logic                      rf_write_en,
  output logic [RF_ADDR_BUS-1:0]    rf_write_addr,
  output logic [DATA_BUS-1:0]       rf_write_data,
  output logic                      rf_write_lo_en,
  output logic [DATA_BUS-1:0]       rf_write_lo_data,
  output logic                      exc_valid,
  output logic [EXC_TYPE_WIDTH-1:0] exc_type,
  output logic [ADDR_BUS-1:0]       exc_epc,
  output logic                      exc_is_delayslot,
  output logic                      flush,
  input  logic                      flush_ack,
  output logic [PERF_CNT_WIDTH-1:0] commit_count
);

  commit_state_e state_q, state_d;

  logic                      rf_add_q, rf_add_d;
  logic                      rf_we_q, rf_we_d;
  logic [RF_ADDR_BUS-1:0]    rf_addr_q, rf_addr_d;
  logic [DATA_BUS-1:0]       rf_data_q, rf_data_d;
  logic                      rf_lo_we_q, rf_lo_we_d;
  logic [DATA_BUS-1:0]       rf_lo_data_q, rf_lo_data_d;
  logic                      exc_valid_q, exc_valid_d;
  logic [EXC_TYPE_WIDTH-1:0] exc_type_q, exc_type_d;
  logic [ADDR_BUS-1:0]       exc_epc_q, exc_epc_d;
  logic                      exc_ds_q, exc_ds_d;
  logic                      flush_q, flush_d;
  logic [PERF_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic pop;
  logic head_exc;

  assign pop      = (state_q == ST_RUN) & rob.can_commit & ~halt;
  assign head_exc = (rob.exception_type != EXC_NONE);
  assign rob.commit_en = pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (pop && head_exc) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_ack) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rf_add_d     = 1'b0;
    rf_we_d      = 1'b0;
    rf_addr_d    = '0;
    rf_data_d    = '0;
    rf_lo_we_d   = 1'b0;
    rf_lo_data_d = '0;
    exc_valid_d  = 1'b0;
    exc_type_d   = exc_type_q;
    exc_epc_d    = exc_epc_q;
    exc_ds_d     = exc_ds_q;
    cnt_d        = cnt_q;
    flush_d      = (state_d == ST_FLUSH);
    unique case (1'b1)
      pop && !head_exc: begin
        rf_add_d     = rob.reg_write_add;
        rf_we_d      = rob.reg_write_en;
        rf_addr_d    = rob.reg_write_addr;
        rf_data_d    = rob.reg_write_data;
        rf_lo_we_d   = rob.reg_write_lo_en;
        rf_lo_data_d = rob.reg_write_lo_data;
        cnt_d        = cnt_q + 1'b1;
      end
      pop && head_exc: begin
        exc_valid_d = 1'b1;
        exc_type_d  = rob.exception_type;
        exc_epc_d   = calc_epc(rob.pc, rob.is_delayslot);
        exc_ds_d    = rob.is_delayslot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_add_q     <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      rf_lo_we_q   <= 1'b0;
      rf_lo_data_q <= '0;
      exc_valid_q  <= 1'b0;
      exc_type_q   <= '0;
      exc_epc_q    <= '0;
      exc_ds_q     <= 1'b0;
      flush_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rf_add_q     <= rf_add_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      rf_lo_we_q   <= rf_lo_we_d;
      rf_lo_data_q <= rf_lo_data_d;
      exc_valid_q  <= exc_valid_d;
      exc_type_q   <= exc_type_d;
      exc_epc_q    <= exc_epc_d;
      exc_ds_q     <= exc_ds_d;
      flush_q      <= flush_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rf_write_add     = rf_add_q;
  assign rf_write_en      = rf_we_q;
  assign rf_write_addr    = rf_addr_q;
  assign rf_write_data    = rf_data_q;
  assign rf_write_lo_en   = rf_lo_we_q;
  assign rf_write_lo_data = rf_lo_data_q;
  assign exc_valid        = exc_valid_q;
  assign exc_type         = exc_type_q;
  assign exc_epc          = exc_epc_q;
  assign exc_is_delayslot = exc_ds_q;
  assign flush            = flush_q;
  assign commit_count     = cnt_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl; narrow counter
// so the wrap case is reachable.
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  localparam int PCW = 4;

  logic clk = 1'b0;
  logic rst;
  logic halt;
  logic flush_ack;

  logic                    rf_write_add;
  logic                    rf_write_en;
  logic [4:0]              rf_write_addr;
  logic [31:0]             rf_write_data;
  logic                    rf_write_lo_en;
  logic [31:0]             rf_write_lo_data;
  logic                    exc_valid;
  logic [EXC_TYPE_BUS-1:0] exc_type;
  logic [31:0]             exc_epc;
  logic                    exc_is_delayslot;
  logic                    flush;
  logic [PCW-1:0]          commit_count;

  int n_chk  = 0;
  int n_fail = 0;

  rob_commit_ctrl_if rob_if ();

  rob_commit_ctrl #(
    .PERF_CNT_WIDTH(PCW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rob              (rob_if.slave),
    .halt             (halt),
    .rf_write_add     (rf_write_add),
    .rf_write_en      (rf_write_en),
    .rf_write_addr    (rf_write_addr),
    .rf_write_data    (rf_write_data),
    .rf_write_lo_en   (rf_write_lo_en),
    .rf_write_lo_data (rf_write_lo_data),
    .exc_valid        (exc_valid),
    .exc_type         (exc_type),
    .exc_epc          (exc_epc),
    .exc_is_delayslot (exc_is_delayslot),
    .flush            (flush),
    .flush_ack        (flush_ack),
    .commit_count     (commit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic head(input logic        we,
                      input logic [4:0]  addr,
                      input logic [31:0] data,
                      input logic        lo_we,
                      input logic [31:0] lo,
                      input logic [4:0]  exc,
                      input logic        ds,
                      input logic [31:0] pc);
    rob_if.reg_write_add     = we;
    rob_if.reg_write_en      = we;
    rob_if.reg_write_addr    = addr;
    rob_if.reg_write_data    = data;
    rob_if.reg_write_lo_en   = lo_we;
    rob_if.reg_write_lo_data = lo;
    rob_if.exception_type    = exc;
    rob_if.is_delayslot      = ds;
    rob_if.pc                = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    halt = 1'b0;
    flush_ack = 1'b0;
    rob_if.can_commit = 1'b0;
    head(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_rf_we", rf_write_en, 0);
    check("rst_lo_we", rf_write_lo_en, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_epc", exc_epc, 0);
    check("rst_flush", flush, 0);
    check("rst_cnt", commit_count, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_cen0", rob_if.commit_en, 0);
    rob_if.can_commit = 1'b1;
    #1;
    check("rst_cen1", rob_if.commit_en, 1);
    rob_if.can_commit = 1'b0;

    // back-to-back pops
    tick();
    rob_if.can_commit = 1'b1;
    head(1, 5'd3, 32'h11, 0, 0, 0, 0, 32'h100);
    @(negedge clk);
    check("b2b_cen0", rob_if.commit_en, 1);
    tick();
    check("b2b_we0", rf_write_en, 1);
    check("b2b_add0", rf_write_add, 1);
    check("b2b_addr0", rf_write_addr, 3);
    check("b2b_data0", rf_write_data, 32'h11);
    head(1, 5'd4, 32'h22, 0, 0, 0, 0, 32'h104);
    @(negedge clk);
    check("b2b_cen1", rob_if.commit_en, 1);
    tick();
    check("b2b_addr1", rf_write_addr, 4);
    check("b2b_data1", rf_write_data, 32'h22);
    head(0, 0, 0, 1, 32'h33, 0, 0, 32'h108);
    @(negedge clk);
    check("b2b_cen2", rob_if.commit_en, 1);
    tick();
    check("b2b_we2", rf_write_en, 0);
    check("b2b_lo_we", rf_write_lo_en, 1);
    check("b2b_lo_data", rf_write_lo_data, 32'h33);
    check("b2b_cnt", commit_count, 3);
    rob_if.can_commit = 1'b0;
    tick();
    check("b2b_lo_pulse", rf_write_lo_en, 0);

    // halt stalls retirement
    halt = 1'b1;
    rob_if.can_commit = 1'b1;
    head(1, 5'd5, 32'h55, 0, 0, 0, 0, 32'h10c);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_cen", rob_if.commit_en, 0);
      tick();
      check("halt_we", rf_write_en, 0);
    end
    check("halt_cnt", commit_count, 3);
    halt = 1'b0;
    @(negedge clk);
    check("unhalt_cen", rob_if.commit_en, 1);
    tick();
    check("unhalt_we", rf_write_en, 1);
    check("unhalt_data", rf_write_data, 32'h55);
    check("unhalt_cnt", commit_count, 4);
    rob_if.can_commit = 1'b0;

    // flush_ack outside FLUSH has no effect
    flush_ack = 1'b1;
    tick();
    check("ack_run_flush", flush, 0);
    flush_ack = 1'b0;

    // exception, non delay slot
    rob_if.can_commit = 1'b1;
    head(1, 5'd7, 32'h77, 0, 0, 5'h0c, 0, 32'hbfc00010);
    tick();
    check("exc_valid", exc_valid, 1);
    check("exc_type", exc_type, 5'h0c);
    check("exc_epc", exc_epc, 32'hbfc00010);
    check("exc_ds", exc_is_delayslot, 0);
    check("exc_flush", flush, 1);
    check("exc_we", rf_write_en, 0);
    check("exc_cnt", commit_count, 4);
    head(1, 5'd6, 32'h66, 0, 0, 0, 0, 32'hbfc00380);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) flush_ack = 1'b1;
      @(negedge clk);
      check("fl_cen", rob_if.commit_en, 0);
      tick();
      if (i == 1) check("fl_pulse", exc_valid, 0);
      if (i < 5) check("fl_hold", flush, 1);
    end
    flush_ack = 1'b0;
    check("fl_exit", flush, 0);
    check("fl_we", rf_write_en, 0);
    @(negedge clk);
    check("fl_resume_cen", rob_if.commit_en, 1);
    tick();
    check("fl_resume_data", rf_write_data, 32'h66);
    check("fl_resume_cnt", commit_count, 5);
    check("fl_type_held", exc_type, 5'h0c);
    rob_if.can_commit = 1'b0;

    // delay-slot exception, ack on first flush cycle
    rob_if.can_commit = 1'b1;
    head(0, 0, 0, 0, 0, 5'h04, 1, 32'hbfc00020);
    tick();
    rob_if.can_commit = 1'b0;
    check("ds_epc", exc_epc, 32'hbfc0001c);
    check("ds_bd", exc_is_delayslot, 1);
    check("ds_type", exc_type, 5'h04);
    check("ds_flush", flush, 1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("ds_min_flush", flush, 0);
    check("ds_pulse", exc_valid, 0);

    // async reset in FLUSH, then counter wrap
    rob_if.can_commit = 1'b1;
    head(0, 0, 0, 0, 0, 5'h08, 0, 32'h200);
    tick();
    rob_if.can_commit = 1'b0;
    check("ar_flush_pre", flush, 1);
    check("ar_cnt_pre", commit_count, 5);
    #2 rst = 1'b0;
    #1;
    check("ar_flush", flush, 0);
    check("ar_cnt", commit_count, 0);
    check("ar_epc", exc_epc, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("ar_state_run", rob_if.commit_en, 0);
    rob_if.can_commit = 1'b1;
    head(1, 5'd1, 32'h1, 0, 0, 0, 0, 32'h300);
    for (int i = 0; i < 15; i++) tick();
    check("wrap_ones", commit_count, 4'hf);
    tick();
    rob_if.can_commit = 1'b0;
    check("wrap_zero", commit_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
